nibbler_core: RTL and testbench

NIBBLER_CORE -- requirements
Module: nibbler_core

---
 rtl/nibbler_pkg.sv | 24 ++
 rtl/nibbler_call_stack.sv | 47 ++++
 rtl/nibbler_core.sv | 199 +++++++++++++++++++
 tb/tb_nibbler_core.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
// Shared types for the nibbler core: opcodes, sequencer states and
// the width derivations used by every nibbler module.
package nibbler_pkg;

    typedef enum logic [3:0] {
        OP_JC, OP_JNC, OP_JZ, OP_JNZ,
        OP_JMP, OP_CALL, OP_RET, OP_LDI,
        OP_LD, OP_ST, OP_ADDI, OP_ADDM,
        OP_CMPI, OP_NANDI, OP_IN, OP_OUT
    } op_t;

    typedef enum logic [1:0] {
        S_FETCH, S_ADDR, S_MEMRD, S_EXEC
    } state_t;

    function automatic int rom_w(input int dw);
        return 4 + dw;
    endfunction

    function automatic int addr_w(input int dw);
        return dw + rom_w(dw);
    endfunction

endpackage

// File: rtl/nibbler_call_stack.sv
// Return-address stack; push when full and pop when empty are ignored,
// the caller flags those as errors.
module nibbler_call_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data
);

    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]  sp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign full   = (sp == SP_W'(DEPTH));
    assign empty  = (sp == '0);
    assign wr_idx = IDX_W'(sp);
    assign rd_idx = IDX_W'(sp - SP_W'(1));
    assign data   = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/nibbler_core.sv
// Nibbler accumulator CPU: multi-cycle sequencer, ALU, I/O ports
// and a hardware return stack.
module nibbler_core
    import nibbler_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int N_IN = 3,
    parameter int N_OUT = 3,
    parameter int STACK_DEPTH = 4,
    localparam int ROM_W = rom_w(DATA_W),
    localparam int ADDR_W = addr_w(DATA_W)
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [ROM_W-1:0]        rom_data,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic                    ram_we,
    output logic                    ram_re,
    output logic [DATA_W-1:0]       ram_wdata,
    input  logic [DATA_W-1:0]       ram_rdata,
    input  logic [N_IN*DATA_W-1:0]  in_port,
    output logic [N_OUT*DATA_W-1:0] out_port,
    output logic [N_OUT-1:0]        out_strobe,
    output logic [DATA_W-1:0]       acc,
    output logic                    carry,
    output logic                    zero,
    output logic [1:0]              stk_err
);

    state_t              state, state_d;
    op_t                 op;
    logic [DATA_W-1:0]   opnd;
    logic [ADDR_W-1:0]   pc, target;
    logic [DATA_W-1:0]   acc_q;
    logic                c_q, z_q;
    logic [1:0]          err_q;
    logic [N_OUT*DATA_W-1:0] out_q;
    logic [N_OUT-1:0]    strobe_q;

    logic [DATA_W-1:0]   in_val, addend, nand_v;
    logic [DATA_W:0]     sum;
    logic                taken;
    logic                stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_W-1:0]   stk_data;
    op_t                 fetch_op;

    assign fetch_op = op_t'(rom_data[ROM_W-1:DATA_W]);

    always_comb begin
        state_d = state;
        unique case (state)
            S_FETCH: begin
                case (fetch_op)
                    OP_LDI, OP_ADDI, OP_CMPI, OP_NANDI,
                    OP_IN, OP_OUT, OP_RET: state_d = S_EXEC;
                    default:               state_d = S_ADDR;
                endcase
            end
            S_ADDR: begin
                if (op == OP_LD || op == OP_ADDM) state_d = S_MEMRD;
                else                              state_d = S_EXEC;
            end
            S_MEMRD: state_d = S_EXEC;
            S_EXEC:  state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        in_val = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (opnd == DATA_W'(i)) in_val = in_port[i*DATA_W +: DATA_W];
        end
        addend = (op == OP_ADDM) ? ram_rdata : opnd;
        sum    = {1'b0, acc_q} + {1'b0, addend};
        nand_v = ~(acc_q & opnd);
        case (op)
            OP_JC:   taken = c_q;
            OP_JNC:  taken = !c_q;
            OP_JZ:   taken = z_q;
            OP_JNZ:  taken = !z_q;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign stk_push = !reset && state == S_EXEC && op == OP_CALL;
    assign stk_pop  = !reset && state == S_EXEC && op == OP_RET;

    nibbler_call_stack #(
        .DEPTH(STACK_DEPTH),
        .WIDTH(ADDR_W)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_data(pc),
        .full     (stk_full),
        .empty    (stk_empty),
        .data     (stk_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            op       <= OP_JC;
            opnd     <= '0;
            pc       <= '0;
            target   <= '0;
            acc_q    <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            err_q    <= 2'b00;
            out_q    <= '0;
            strobe_q <= '0;
        end else begin
            state    <= state_d;
            strobe_q <= '0;
            unique case (state)
                S_FETCH: begin
                    op   <= fetch_op;
                    opnd <= rom_data[DATA_W-1:0];
                    pc   <= pc + 1'b1;
                end
                S_ADDR: begin
                    target <= {opnd, rom_data};
                    pc     <= pc + 1'b1;
                end
                S_MEMRD: ;
                S_EXEC: begin
                    case (op)
                        OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP: begin
                            if (taken) pc <= target;
                        end
                        OP_CALL: begin
                            pc <= target;
                            if (stk_full) err_q[0] <= 1'b1;
                        end
                        OP_RET: begin
                            if (stk_empty) err_q[1] <= 1'b1;
                            else           pc <= stk_data;
                        end
                        OP_LDI: begin
                            acc_q <= opnd;
                            z_q   <= (opnd == '0);
                        end
                        OP_LD: begin
                            acc_q <= ram_rdata;
                            z_q   <= (ram_rdata == '0);
                        end
                        OP_ADDI, OP_ADDM: begin
                            acc_q <= sum[DATA_W-1:0];
                            c_q   <= sum[DATA_W];
                            z_q   <= (sum[DATA_W-1:0] == '0);
                        end
                        OP_CMPI: begin
                            c_q <= (acc_q >= opnd);
                            z_q <= (acc_q == opnd);
                        end
                        OP_NANDI: begin
                            acc_q <= nand_v;
                            z_q   <= (nand_v == '0);
                        end
                        OP_IN: begin
                            acc_q <= in_val;
                            z_q   <= (in_val == '0);
                        end
                        OP_OUT: begin
                            for (int i = 0; i < N_OUT; i++) begin
                                if (opnd == DATA_W'(i)) begin
                                    out_q[i*DATA_W +: DATA_W] <= acc_q;
                                    strobe_q[i] <= 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Strobes are masked by reset so an in-flight access never lands.
    assign ram_we     = !reset && state == S_EXEC && op == OP_ST;
    assign ram_re     = !reset && state == S_MEMRD;
    assign rom_addr   = pc;
    assign ram_addr   = target;
    assign ram_wdata  = acc_q;
    assign acc        = acc_q;
    assign carry      = c_q;
    assign zero       = z_q;
    assign stk_err    = err_q;
    assign out_port   = out_q;
    assign out_strobe = strobe_q;

endmodule

// File: tb/tb_nibbler_core.sv
// Directed-vector bench for nibbler_core with a behavioural ROM and
// a one-cycle-latency RAM.
module tb_nibbler_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic [11:0] ram_addr;
    logic        ram_we, ram_re;
    logic [3:0]  ram_wdata;
    logic [3:0]  ram_rdata = '0;
    logic [11:0] in_port;
    logic [11:0] out_port;
    logic [2:0]  out_strobe;
    logic [3:0]  acc;
    logic        carry, zero;
    logic [1:0]  stk_err;

    logic [7:0] rom [0:4095];
    logic [3:0] ram [0:4095];
    int errs = 0;
    int checks = 0;
    int we_cnt = 0;
    int stb_cnt = 0;

    nibbler_core #(
        .DATA_W(4),
        .N_IN(3),
        .N_OUT(3),
        .STACK_DEPTH(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .out_strobe(out_strobe),
        .acc       (acc),
        .carry     (carry),
        .zero      (zero),
        .stk_err   (stk_err)
    );

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram[ram_addr];
        if (ram_we) we_cnt <= we_cnt + 1;
        stb_cnt <= stb_cnt + $countones(out_strobe);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h70;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        clear_rom();
        in_port = '0;
        reset = 1'b1;
        step(2);
        checks++;
        if (rom_addr !== 12'h000) begin
            $display("FAIL reset_pc got %h want 000", rom_addr); errs++;
        end
        checks++;
        if ({acc, carry, zero} !== 6'b0) begin
            $display("FAIL reset_acc got %h/%b/%b want 0/0/0",
                     acc, carry, zero); errs++;
        end
        checks++;
        if (stk_err !== 2'b00) begin
            $display("FAIL reset_err got %b want 00", stk_err); errs++;
        end
        checks++;
        if (out_port !== 12'h000) begin
            $display("FAIL reset_port got %h want 000", out_port); errs++;
        end
        checks++;
        if ({ram_we, ram_re, out_strobe} !== 5'b0) begin
            $display("FAIL reset_strobes got %b%b%b want 0",
                     ram_we, ram_re, out_strobe); errs++;
        end
        checks++;
        if (ram_addr !== 12'h000) begin
            $display("FAIL reset_ramaddr got %h want 000", ram_addr); errs++;
        end
    endtask

    task automatic test_alu;
        clear_rom();
        rom[0] = 8'h77;
        rom[1] = 8'hAA;
        rom[2] = 8'hAF;
        rom[3] = 8'hD0;
        do_reset();
        step(2);
        checks++;
        if ({acc, rom_addr} !== {4'h7, 12'h001}) begin
            $display("FAIL ldi got acc=%h pc=%h want 7/001", acc, rom_addr);
            errs++;
        end
        step(1);
        checks++;
        if (acc !== 4'h7) begin
            $display("FAIL addi_early got %h want 7", acc); errs++;
        end
        step(1);
        checks++;
        if ({acc, carry, zero} !== {4'h1, 1'b1, 1'b0}) begin
            $display("FAIL addi got %h/%b/%b want 1/1/0", acc, carry, zero);
            errs++;
        end
        step(2);
        checks++;
        if ({acc, carry, zero} !== {4'h0, 1'b1, 1'b1}) begin
            $display("FAIL addi_zero got %h/%b/%b want 0/1/1",
                     acc, carry, zero); errs++;
        end
        step(2);
        checks++;
        if ({acc, carry, zero} !== {4'hF, 1'b1, 1'b0}) begin
            $display("FAIL nandi got %h/%b/%b want f/1/0", acc, carry, zero);
            errs++;
        end
    endtask

    task automatic test_cmp_jz;
        clear_rom();
        rom[0] = 8'h75;
        rom[1] = 8'hC5;
        rom[2] = 8'h21;
        rom[3] = 8'h23;
        do_reset();
        step(4);
        checks++;
        if ({acc, carry, zero} !== {4'h5, 2'b11}) begin
            $display("FAIL cmp_eq got %h/%b/%b want 5/1/1", acc, carry, zero);
            errs++;
        end
        step(3);
        checks++;
        if (rom_addr !== 12'h123) begin
            $display("FAIL jz_taken got %h want 123", rom_addr); errs++;
        end
        rom[1] = 8'hC6;
        do_reset();
        step(4);
        checks++;
        if ({carry, zero} !== 2'b00) begin
            $display("FAIL cmp_lt got %b%b want 00", carry, zero); errs++;
        end
        step(3);
        checks++;
        if (rom_addr !== 12'h004) begin
            $display("FAIL jz_fall got %h want 004", rom_addr); errs++;
        end
    endtask

    task automatic test_mem;
        int we0;
        clear_rom();
        rom[0] = 8'h73;
        rom[1] = 8'h90;
        rom[2] = 8'h40;
        rom[3] = 8'h70;
        rom[4] = 8'h80;
        rom[5] = 8'h40;
        rom[6] = 8'hB0;
        rom[7] = 8'h40;
        do_reset();
        we0 = we_cnt;
        step(4);
        checks++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 12'h040, 4'h3}) begin
            $display("FAIL st got we=%b a=%h d=%h want 1/040/3",
                     ram_we, ram_addr, ram_wdata); errs++;
        end
        step(1);
        checks++;
        if (ram_we !== 1'b0) begin
            $display("FAIL st_len got we=%b want 0", ram_we); errs++;
        end
        step(4);
        checks++;
        if ({ram_re, ram_addr, acc} !== {1'b1, 12'h040, 4'h0}) begin
            $display("FAIL memrd got re=%b a=%h acc=%h want 1/040/0",
                     ram_re, ram_addr, acc); errs++;
        end
        step(2);
        checks++;
        if ({acc, zero} !== {4'h3, 1'b0}) begin
            $display("FAIL ld got %h/%b want 3/0", acc, zero); errs++;
        end
        step(4);
        checks++;
        if ({acc, carry} !== {4'h6, 1'b0}) begin
            $display("FAIL addm got %h/%b want 6/0", acc, carry); errs++;
        end
        checks++;
        if (we_cnt - we0 !== 1) begin
            $display("FAIL we_count got %0d want 1", we_cnt - we0); errs++;
        end
    endtask

    task automatic test_stack;
        clear_rom();
        rom[12'h000] = 8'h50;
        rom[12'h001] = 8'h10;
        rom[12'h002] = 8'h60;
        rom[12'h003] = 8'h60;
        rom[12'h010] = 8'h50;
        rom[12'h011] = 8'h20;
        rom[12'h012] = 8'h60;
        rom[12'h020] = 8'h50;
        rom[12'h021] = 8'h30;
        rom[12'h030] = 8'h60;
        do_reset();
        step(6);
        checks++;
        if ({stk_err, rom_addr} !== {2'b00, 12'h020}) begin
            $display("FAIL call2 got err=%b pc=%h want 00/020",
                     stk_err, rom_addr); errs++;
        end
        step(3);
        checks++;
        if ({stk_err, rom_addr} !== {2'b01, 12'h030}) begin
            $display("FAIL call3 got err=%b pc=%h want 01/030",
                     stk_err, rom_addr); errs++;
        end
        step(2);
        checks++;
        if ({stk_err, rom_addr} !== {2'b01, 12'h012}) begin
            $display("FAIL ret1 got err=%b pc=%h want 01/012",
                     stk_err, rom_addr); errs++;
        end
        step(2);
        checks++;
        if ({stk_err, rom_addr} !== {2'b01, 12'h002}) begin
            $display("FAIL ret2 got err=%b pc=%h want 01/002",
                     stk_err, rom_addr); errs++;
        end
        step(2);
        checks++;
        if ({stk_err, rom_addr} !== {2'b11, 12'h003}) begin
            $display("FAIL ret3 got err=%b pc=%h want 11/003",
                     stk_err, rom_addr); errs++;
        end
        step(2);
        checks++;
        if ({stk_err, rom_addr} !== {2'b11, 12'h004}) begin
            $display("FAIL ret4 got err=%b pc=%h want 11/004",
                     stk_err, rom_addr); errs++;
        end
    endtask

    task automatic test_io;
        int s0;
        clear_rom();
        in_port = 12'h9A5;
        rom[0] = 8'hE2;
        rom[1] = 8'hF1;
        rom[2] = 8'hF7;
        rom[3] = 8'hE5;
        do_reset();
        s0 = stb_cnt;
        step(2);
        checks++;
        if ({acc, zero} !== {4'h9, 1'b0}) begin
            $display("FAIL in2 got %h/%b want 9/0", acc, zero); errs++;
        end
        step(2);
        checks++;
        if ({out_port, out_strobe} !== {12'h090, 3'b010}) begin
            $display("FAIL out1 got %h/%b want 090/010",
                     out_port, out_strobe); errs++;
        end
        step(2);
        checks++;
        if ({out_port, out_strobe} !== {12'h090, 3'b000}) begin
            $display("FAIL out7 got %h/%b want 090/000",
                     out_port, out_strobe); errs++;
        end
        step(2);
        checks++;
        if ({acc, zero} !== {4'h0, 1'b1}) begin
            $display("FAIL in5 got %h/%b want 0/1", acc, zero); errs++;
        end
        checks++;
        if (stb_cnt - s0 !== 1) begin
            $display("FAIL strobe_count got %0d want 1", stb_cnt - s0);
            errs++;
        end
        in_port = '0;
    endtask

    task automatic test_reset_midflight;
        int we0;
        clear_rom();
        rom[0] = 8'h73;
        rom[1] = 8'hF0;
        rom[2] = 8'h90;
        rom[3] = 8'h40;
        do_reset();
        we0 = we_cnt;
        step(5);
        checks++;
        if (out_port !== 12'h003) begin
            $display("FAIL pre_reset_port got %h want 003", out_port); errs++;
        end
        reset = 1'b1;
        step(1);
        checks++;
        if ({acc, carry, zero, stk_err} !== 8'h00) begin
            $display("FAIL mid_regs got %h/%b/%b/%b want 0",
                     acc, carry, zero, stk_err); errs++;
        end
        checks++;
        if ({out_port, rom_addr, ram_addr} !== 36'h0) begin
            $display("FAIL mid_addr got %h/%h/%h want 0",
                     out_port, rom_addr, ram_addr); errs++;
        end
        step(1);
        checks++;
        if ({ram_we, ram_re, out_strobe} !== 5'b0) begin
            $display("FAIL mid_strobes got %b%b%b want 0",
                     ram_we, ram_re, out_strobe); errs++;
        end
        reset = 1'b0;
        step(2);
        checks++;
        if ({acc, rom_addr} !== {4'h3, 12'h001}) begin
            $display("FAIL restart got acc=%h pc=%h want 3/001",
                     acc, rom_addr); errs++;
        end
        checks++;
        if (we_cnt - we0 !== 0) begin
            $display("FAIL mid_we got %0d want 0", we_cnt - we0); errs++;
        end
    endtask

    task automatic test_wrap;
        clear_rom();
        rom[12'h000] = 8'h4F;
        rom[12'h001] = 8'hFF;
        rom[12'hFFF] = 8'h76;
        do_reset();
        step(3);
        checks++;
        if (rom_addr !== 12'hFFF) begin
            $display("FAIL jmp_fff got %h want fff", rom_addr); errs++;
        end
        step(2);
        checks++;
        if ({acc, rom_addr} !== {4'h6, 12'h000}) begin
            $display("FAIL pc_wrap got acc=%h pc=%h want 6/000",
                     acc, rom_addr); errs++;
        end
    endtask

    initial begin
        reset = 1'b1;
        in_port = '0;
        test_reset();
        test_alu();
        test_cmp_jz();
        test_mem();
        test_stack();
        test_io();
        test_reset_midflight();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
